axi_mem_responder: RTL and testbench

AXI4 slave memory endpoint that answers bursts issued through the axi node. It serves as a local data RAM or scratch region on one node slave port (default window 0x0010_0000).
Reads and writes share a single-port word array. One transaction is in flight at a time, with round-robin arbitration between the AW and AR channels. User, cache, prot, lock, qos, region and size are not ports; the integrating wrapper ties or ignores them. Only full-width INCR bursts are supported.

---
 rtl/axi_mem_pkg.sv | 22 ++
 rtl/axi_mem_responder_if.sv | 67 ++++++
 rtl/axi_mem_array.sv | 41 ++++
 rtl/axi_mem_responder.sv | 189 ++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: shared definitions for the AXI memory responder.
//   RESP_*          AXI response encodings used on b_resp / r_resp
//   state_t         responder FSM states
//   bytes_per_beat  bytes in one full-width data beat
package axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WRESP = 2'd2,
    READ  = 2'd3
  } state_t;

  function automatic int bytes_per_beat(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axi_mem_responder_if.sv
// axi_mem_responder_if: reduced AXI4 bus (AW, W, B, AR, R channels) between a
// node slave port and the memory responder.
//   master modport: drives valids / addresses / write data / response readies
//   slave modport : drives address and data readies, B and R responses
interface axi_mem_responder_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
);

  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [AXI_ID_WIDTH-1:0]     aw_id;

  logic                        w_valid;
  logic                        w_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;

  logic                        b_valid;
  logic                        b_ready;
  logic [1:0]                  b_resp;
  logic [AXI_ID_WIDTH-1:0]     b_id;

  logic                        ar_valid;
  logic                        ar_ready;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [AXI_ID_WIDTH-1:0]     ar_id;

  logic                        r_valid;
  logic                        r_ready;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_ID_WIDTH-1:0]     r_id;

  modport master (
    output aw_valid, aw_addr, aw_len, aw_id,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_resp, b_id,
    output b_ready,
    output ar_valid, ar_addr, ar_len, ar_id,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last, r_id,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_addr, aw_len, aw_id,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_resp, b_id,
    input  b_ready,
    input  ar_valid, ar_addr, ar_len, ar_id,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last, r_id,
    input  r_ready
  );

endinterface

// File: rtl/axi_mem_array.sv
// axi_mem_array: single-port word array with per-byte write enables and a
// registered read port (one-cycle read latency). Contents are not reset.
//   clk    clock
//   en     access enable
//   we     1 = write strobed bytes, 0 = read word into rdata
//   idx    word index
//   wdata  write word
//   wstrb  byte enables
//   rdata  registered read word; holds its value while no read is issued
module axi_mem_array #(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 1024,
  localparam int IDX_W      = $clog2(DEPTH),
  localparam int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb[b]) begin
            mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave memory endpoint, one transaction at a time,
// round-robin between AW and AR, full-width INCR bursts only.
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  slave side of the AXI bus (AW/W/B/AR/R)
//
//   state | meaning
//   IDLE  | waiting for an address; round-robin picks AW or AR
//   WRITE | consuming exactly len+1 W beats
//   WRESP | presenting B until b_ready
//   READ  | presenting R beats, next word fetched on each handshake
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        AXI_ID_WIDTH   = 4,
  parameter int                        MEM_DEPTH      = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0010_0000
) (
  input logic clk,
  input logic rst,
  axi_mem_responder_if.slave bus
);

  localparam int BPB      = bytes_per_beat(AXI_DATA_WIDTH);
  localparam int OFF_BITS = $clog2(BPB);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(BPB);
  localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_A   = AXI_ADDR_WIDTH'(MEM_DEPTH);
  localparam logic RR_WR = 1'b0;
  localparam logic RR_RD = 1'b1;

  state_t                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]                  len_q;
  logic [7:0]                  beat_q;
  logic [AXI_ID_WIDTH-1:0]     id_q;
  logic                        dec_q, slv_q, rr_q;
  logic                        r_last_q;
  logic [1:0]                  r_resp_q;

  logic                        aw_hs, ar_hs, w_hs, r_hs;
  logic [AXI_ADDR_WIDTH-1:0]   mem_addr, mem_off, mem_word;
  logic                        mem_in_range, mem_en, mem_we;
  logic [IDX_W-1:0]            mem_idx;
  logic [AXI_DATA_WIDTH-1:0]   mem_rdata;

  assign aw_hs = bus.aw_valid & bus.aw_ready;
  assign ar_hs = bus.ar_valid & bus.ar_ready;
  assign w_hs  = (state_q == WRITE) & bus.w_valid;
  assign r_hs  = (state_q == READ) & bus.r_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (aw_hs)      state_d = WRITE;
        else if (ar_hs) state_d = READ;
      end
      WRITE: if (w_hs && beat_q == len_q)  state_d = WRESP;
      WRESP: if (bus.b_ready)              state_d = IDLE;
      READ:  if (r_hs && r_last_q)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    bus.aw_ready = 1'b0;
    bus.ar_ready = 1'b0;
    bus.w_ready  = 1'b0;
    bus.b_valid  = 1'b0;
    bus.r_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.aw_ready = bus.aw_valid && (!bus.ar_valid || rr_q == RR_WR);
        bus.ar_ready = bus.ar_valid && (!bus.aw_valid || rr_q == RR_RD);
      end
      WRITE:   bus.w_ready = 1'b1;
      WRESP:   bus.b_valid = 1'b1;
      READ:    bus.r_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.b_resp = dec_q ? RESP_DECERR : (slv_q ? RESP_SLVERR : RESP_OKAY);
  assign bus.b_id   = id_q;
  assign bus.r_id   = id_q;
  assign bus.r_last = r_last_q;
  assign bus.r_resp = r_resp_q;
  // Out-of-range beats still fetch (truncated index), so mask the data here.
  assign bus.r_data = (state_q == READ && r_resp_q == RESP_OKAY) ? mem_rdata : '0;

  // Address of the beat being accessed this cycle: the incoming AR address in
  // IDLE, the next beat's address in READ (prefetch on handshake), else the
  // current beat's address.
  always_comb begin
    unique case (state_q)
      IDLE:    mem_addr = bus.ar_addr;
      READ:    mem_addr = addr_q + ADDR_STEP;
      default: mem_addr = addr_q;
    endcase
  end

  // Below-base addresses wrap to huge offsets and fail the unsigned compare.
  assign mem_off      = mem_addr - BASE_ADDR;
  assign mem_word     = mem_off >> OFF_BITS;
  assign mem_in_range = mem_word < DEPTH_A;
  assign mem_idx      = mem_word[IDX_W-1:0];
  assign mem_en       = ar_hs | (w_hs & mem_in_range) | (r_hs & ~r_last_q);
  assign mem_we       = w_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      id_q     <= '0;
      dec_q    <= 1'b0;
      slv_q    <= 1'b0;
      rr_q     <= RR_WR;
      r_last_q <= 1'b0;
      r_resp_q <= RESP_OKAY;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (aw_hs) begin
            addr_q <= bus.aw_addr;
            len_q  <= bus.aw_len;
            id_q   <= bus.aw_id;
            beat_q <= '0;
            dec_q  <= 1'b0;
            slv_q  <= 1'b0;
            rr_q   <= RR_RD;
          end else if (ar_hs) begin
            addr_q   <= bus.ar_addr;
            len_q    <= bus.ar_len;
            id_q     <= bus.ar_id;
            beat_q   <= '0;
            dec_q    <= 1'b0;
            slv_q    <= 1'b0;
            rr_q     <= RR_WR;
            r_last_q <= (bus.ar_len == 8'd0);
            r_resp_q <= mem_in_range ? RESP_OKAY : RESP_DECERR;
          end
        end
        WRITE: begin
          if (w_hs) begin
            dec_q  <= dec_q | ~mem_in_range;
            slv_q  <= slv_q | (bus.w_last != (beat_q == len_q));
            beat_q <= beat_q + 8'd1;
            addr_q <= addr_q + ADDR_STEP;
          end
        end
        READ: begin
          if (r_hs && !r_last_q) begin
            addr_q   <= mem_addr;
            beat_q   <= beat_q + 8'd1;
            r_last_q <= (beat_q + 8'd1 == len_q);
            r_resp_q <= mem_in_range ? RESP_OKAY : RESP_DECERR;
          end
        end
        default: ;
      endcase
    end
  end

  axi_mem_array #(
    .DATA_WIDTH (AXI_DATA_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (bus.w_data),
    .wstrb (bus.w_strb),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_axi_mem_responder.sv
`timescale 1ns/1ps
// tb_axi_mem_responder: table-driven bench for axi_mem_responder plus
// hand-written sequences for arbitration, 256-beat bursts and reset mid-read.
module tb_axi_mem_responder;
  import axi_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_mem_responder_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4)) bus ();

  axi_mem_responder #(
    .AXI_ADDR_WIDTH (32),
    .AXI_DATA_WIDTH (32),
    .AXI_ID_WIDTH   (4),
    .MEM_DEPTH      (1024),
    .BASE_ADDR      (32'h0010_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    logic [3:0]  strb;
    int          last_at;
    bit          stall;
    logic [31:0] d [4];
    logic [1:0]  resp [4];
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  int total  = 0;
  int passed = 0;
  logic [31:0] dbuf [256];
  logic [1:0]  rbuf [256];
  logic [3:0]  sbuf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(bit wr, logic [31:0] a, logic [7:0] len, logic [3:0] id,
                              logic [3:0] strb, int last_at, bit stall,
                              logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic [31:0] d3,
                              logic [1:0] r0, logic [1:0] r1, logic [1:0] r2, logic [1:0] r3);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = len; v.id = id; v.strb = strb;
    v.last_at = last_at; v.stall = stall;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.resp[0] = r0; v.resp[1] = r1; v.resp[2] = r2; v.resp[3] = r3;
    return v;
  endfunction

  task automatic drive_idle();
    bus.aw_valid = 0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_id = '0;
    bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 0;
    bus.b_ready = 0;
    bus.ar_valid = 0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_id = '0;
    bus.r_ready = 0;
  endtask

  task automatic do_addr(input bit wr, input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    bit ok = 0;
    if (wr) begin
      bus.aw_valid = 1; bus.aw_addr = a; bus.aw_len = len; bus.aw_id = id;
    end else begin
      bus.ar_valid = 1; bus.ar_addr = a; bus.ar_len = len; bus.ar_id = id;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr ? bus.aw_ready : bus.ar_ready) begin ok = 1; break; end
    end
    chk(wr ? "aw_handshake" : "ar_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.aw_valid = 0; bus.ar_valid = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                          input int last_at, input logic [1:0] exp_resp);
    bit ok;
    do_addr(1, a, len, id);
    for (int b = 0; b <= int'(len); b++) begin
      bus.w_valid = 1; bus.w_data = dbuf[b]; bus.w_strb = sbuf; bus.w_last = (b == last_at);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.w_ready) begin ok = 1; break; end
      end
      if (!ok) chk($sformatf("w_ready[%0d]", b), 32'(ok), 32'd1);
      @(posedge clk); #1;
    end
    bus.w_valid = 0; bus.w_last = 0; bus.b_ready = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.b_valid) begin ok = 1; break; end
    end
    chk("b_valid", 32'(ok), 32'd1);
    chk("b_resp", 32'(bus.b_resp), 32'(exp_resp));
    chk("b_id", 32'(bus.b_id), 32'(id));
    @(posedge clk); #1;
    bus.b_ready = 0;
  endtask

  task automatic chk_beat(input int b, input logic [7:0] len, input logic [3:0] id);
    chk($sformatf("r_valid[%0d]", b), 32'(bus.r_valid), 32'd1);
    chk($sformatf("r_data[%0d]", b), bus.r_data, dbuf[b]);
    chk($sformatf("r_resp[%0d]", b), 32'(bus.r_resp), 32'(rbuf[b]));
    chk($sformatf("r_last[%0d]", b), 32'(bus.r_last), 32'(b == int'(len)));
    chk($sformatf("r_id[%0d]", b), 32'(bus.r_id), 32'(id));
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id, input bit stall);
    int n;
    do_addr(0, a, len, id);
    for (int b = 0; b <= int'(len); b++) begin
      if (stall) begin
        bus.r_ready = 0;
        @(negedge clk);
        chk_beat(b, len, id);
        @(posedge clk); #1;
      end
      bus.r_ready = 1;
      n = 0;
      @(negedge clk);
      while (!bus.r_valid && n < 20) begin @(negedge clk); n++; end
      if (!stall) chk($sformatf("r_gap[%0d]", b), 32'(n), 32'd0);
      chk_beat(b, len, id);
      @(posedge clk); #1;
    end
    bus.r_ready = 0;
    @(negedge clk);
    chk("r_valid_end", 32'(bus.r_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vt[0]  = mk(1, 32'h0010_0008, 0, 4'h3, 4'hF, 0, 0, 32'hDEADBEEF, 0, 0, 0, RESP_OKAY, 0, 0, 0);
    vt[1]  = mk(0, 32'h0010_0008, 0, 4'h5, 4'hF, 0, 0, 32'hDEADBEEF, 0, 0, 0, RESP_OKAY, 0, 0, 0);
    vt[2]  = mk(1, 32'h0010_0000, 3, 4'h1, 4'hF, 3, 0, 1, 2, 3, 4, RESP_OKAY, 0, 0, 0);
    vt[3]  = mk(0, 32'h0010_0000, 3, 4'h2, 4'hF, 0, 1, 1, 2, 3, 4,
                RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY);
    vt[4]  = mk(1, 32'h0010_0010, 0, 4'h4, 4'hF, 0, 0, 32'h11223344, 0, 0, 0, RESP_OKAY, 0, 0, 0);
    vt[5]  = mk(1, 32'h0010_0010, 0, 4'h4, 4'h5, 0, 0, 32'hAABBCCDD, 0, 0, 0, RESP_OKAY, 0, 0, 0);
    vt[6]  = mk(0, 32'h0010_0010, 0, 4'h6, 4'hF, 0, 0, 32'h11BB33DD, 0, 0, 0, RESP_OKAY, 0, 0, 0);
    vt[7]  = mk(1, 32'h0010_0FFC, 1, 4'hA, 4'hF, 1, 0, 32'hCAFE0001, 32'hCAFE0002, 0, 0,
                RESP_DECERR, 0, 0, 0);
    vt[8]  = mk(0, 32'h0010_0FFC, 1, 4'hB, 4'hF, 0, 0, 32'hCAFE0001, 0, 0, 0,
                RESP_OKAY, RESP_DECERR, 0, 0);
    vt[9]  = mk(0, 32'h0000_0000, 0, 4'hC, 4'hF, 0, 0, 0, 0, 0, 0, RESP_DECERR, 0, 0, 0);
    vt[10] = mk(1, 32'h0010_0030, 2, 4'hD, 4'hF, 1, 0, 32'h30, 32'h31, 32'h32, 0,
                RESP_SLVERR, 0, 0, 0);
    vt[11] = mk(0, 32'h0010_0033, 2, 4'hE, 4'hF, 0, 1, 32'h30, 32'h31, 32'h32, 0,
                RESP_OKAY, RESP_OKAY, RESP_OKAY, 0);
    vt[12] = mk(0, 32'h000F_FFFC, 0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, RESP_DECERR, 0, 0, 0);

    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_aw_ready", 32'(bus.aw_ready), 32'd0);
    chk("rst_ar_ready", 32'(bus.ar_ready), 32'd0);
    chk("rst_w_ready", 32'(bus.w_ready), 32'd0);
    chk("rst_b_valid", 32'(bus.b_valid), 32'd0);
    chk("rst_r_valid", 32'(bus.r_valid), 32'd0);
    chk("rst_r_data", bus.r_data, 32'd0);
    chk("rst_r_resp", 32'(bus.r_resp), 32'd0);
    chk("rst_b_resp", 32'(bus.b_resp), 32'd0);
    chk("rst_r_last", 32'(bus.r_last), 32'd0);
    chk("rst_b_id", 32'(bus.b_id), 32'd0);
    chk("rst_r_id", 32'(bus.r_id), 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // Simultaneous AW and AR straight after reset: write wins, read follows.
    bus.aw_valid = 1; bus.aw_addr = 32'h0010_0020; bus.aw_len = 0; bus.aw_id = 4'h7;
    bus.ar_valid = 1; bus.ar_addr = 32'h0010_0020; bus.ar_len = 0; bus.ar_id = 4'h8;
    @(negedge clk);
    chk("arb_aw_ready", 32'(bus.aw_ready), 32'd1);
    chk("arb_ar_ready", 32'(bus.ar_ready), 32'd0);
    @(posedge clk); #1;
    bus.aw_valid = 0;
    bus.w_valid = 1; bus.w_data = 32'h5A5A1234; bus.w_strb = 4'hF; bus.w_last = 1;
    @(negedge clk);
    chk("arb_w_ready", 32'(bus.w_ready), 32'd1);
    chk("arb_ar_blocked_w", 32'(bus.ar_ready), 32'd0);
    @(posedge clk); #1;
    bus.w_valid = 0; bus.w_last = 0; bus.b_ready = 1;
    @(negedge clk);
    chk("arb_b_valid", 32'(bus.b_valid), 32'd1);
    chk("arb_b_resp", 32'(bus.b_resp), 32'(RESP_OKAY));
    chk("arb_b_id", 32'(bus.b_id), 32'h7);
    chk("arb_ar_blocked_b", 32'(bus.ar_ready), 32'd0);
    @(posedge clk); #1;
    bus.b_ready = 0;
    @(negedge clk);
    chk("arb_ar_ready", 32'(bus.ar_ready), 32'd1);
    @(posedge clk); #1;
    bus.ar_valid = 0; bus.r_ready = 1;
    @(negedge clk);
    chk("arb_r_valid", 32'(bus.r_valid), 32'd1);
    chk("arb_r_data", bus.r_data, 32'h5A5A1234);
    chk("arb_r_id", 32'(bus.r_id), 32'h8);
    @(posedge clk); #1;
    bus.r_ready = 0;

    for (int k = 0; k < NV; k++) begin
      v = vt[k];
      for (int i = 0; i < 4; i++) begin
        dbuf[i] = v.d[i];
        rbuf[i] = v.resp[i];
      end
      sbuf = v.strb;
      if (v.wr) do_write(v.addr, v.len, v.id, v.last_at, v.resp[0]);
      else      do_read(v.addr, v.len, v.id, v.stall);
    end

    // 256-beat burst each way.
    for (int i = 0; i < 256; i++) begin
      dbuf[i] = 32'h1000_0000 + 32'(i);
      rbuf[i] = RESP_OKAY;
    end
    sbuf = 4'hF;
    do_write(32'h0010_0400, 8'd255, 4'h2, 255, RESP_OKAY);
    do_read(32'h0010_0400, 8'd255, 4'h3, 0);

    // Reset during beat 2 of an 8-beat read.
    bus.ar_valid = 1; bus.ar_addr = 32'h0010_0000; bus.ar_len = 8'd7; bus.ar_id = 4'h9;
    @(negedge clk);
    chk("mid_ar_ready", 32'(bus.ar_ready), 32'd1);
    @(posedge clk); #1;
    bus.ar_valid = 0; bus.r_ready = 1;
    @(negedge clk);
    chk("mid_r_data0", bus.r_data, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_r_data1", bus.r_data, 32'd2);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("mid_rst_r_valid", 32'(bus.r_valid), 32'd0);
    chk("mid_rst_r_last", 32'(bus.r_last), 32'd0);
    @(posedge clk); #1;
    rst = 0; bus.r_ready = 0;
    dbuf[0] = 32'd2; rbuf[0] = RESP_OKAY;
    do_read(32'h0010_0004, 8'd0, 4'h4, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
